ram_rd_stream: RTL

Read-side sequencer for the dual-port register RAM. On a start pulse it walks a contiguous, wrap-around address range and presents each word on a registered valid/ready output stream, one word per cycle when the sink is ready. It sits between the RAM's combinational read port and downstream consumers such as UART/bus transmit paths. It never writes the RAM.

---
 rtl/ram_rd_stream_if.sv | 34 +++
 rtl/ram_rd_stream.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_rd_stream_if.sv
// ram_rd_stream_if: registered valid/ready word stream leaving ram_rd_stream.
// out_last is present only when RAM_RD_LAST_EN is defined.
interface ram_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef RAM_RD_LAST_EN
    logic                  out_last;
`endif

    // Source side: the sequencer drives data/valid and observes ready.
    modport master (
        output out_data,
        output out_valid,
        input  out_ready
`ifdef RAM_RD_LAST_EN
        ,
        output out_last
`endif
    );

    // Sink side: the consumer observes data/valid and drives ready.
    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
`ifdef RAM_RD_LAST_EN
        ,
        input  out_last
`endif
    );
endinterface

// File: rtl/ram_rd_stream.sv
// ram_rd_stream: read-side sequencer for the dual-port register RAM.
// On start it walks a wrap-around address range of len words and presents
// each word on a registered valid/ready stream, one word per cycle when the
// sink is ready. Optional feature macro: RAM_RD_LAST_EN adds out_last.
module ram_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] start_addr,
    input  logic [DEPTH_LOG2:0]   len,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    ram_rd_stream_if.master       stream,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;

    state_t                state;
    state_t                next_state;
    logic [DEPTH_LOG2-1:0] addr;
    logic [DEPTH_LOG2:0]   remaining;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  accept;
    logic                  load;
    logic                  finish;
    logic                  handshake;
`ifdef RAM_RD_LAST_EN
    logic                  last_q;
`endif

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a non-empty start opens a stream, the final accepted word closes it.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (len != '0)) next_state = STREAM;
            STREAM:  if (finish) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output/control decode: start acceptance, word loads and stream completion.
    always_comb begin
        busy      = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
        handshake = valid_q && stream.out_ready;
        case (state)
            IDLE:   accept = start;
            STREAM: begin
                busy   = 1'b1;
                load   = (remaining != '0) && (!valid_q || stream.out_ready);
                finish = (remaining == '0) && handshake;
            end
            default: ;
        endcase
    end

    // Address walk and word countdown; start latches the range even when len is zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (accept) begin
            addr      <= start_addr;
            remaining <= len;
        end else if (load) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
        end
    end

    // Output register: capture RAM data on load, hold under backpressure, clear on a drained handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef RAM_RD_LAST_EN
            last_q  <= 1'b0;
`endif
        end else if (load) begin
            data_q  <= ram_data;
            valid_q <= 1'b1;
`ifdef RAM_RD_LAST_EN
            last_q  <= (remaining == CNT_ONE);
`endif
        end else if (handshake) begin
            valid_q <= 1'b0;
`ifdef RAM_RD_LAST_EN
            last_q  <= 1'b0;
`endif
        end
    end

    // Completion pulse: final word accepted, or a zero-length request taken in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= finish || (accept && (len == '0));
        end
    end

    assign ram_addr         = addr;
    assign stream.out_data  = data_q;
    assign stream.out_valid = valid_q;
`ifdef RAM_RD_LAST_EN
    assign stream.out_last  = last_q;
`endif
endmodule
